// File: rtl/systolic_mm_top.sv
// 4x4 output-stationary systolic matrix-multiply engine. The host loads the operand,
// instruction and result memories; the engine runs a list of tile multiplies on ap_start.
module systolic_mm_top (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  addrA,
   input  logic [15:0] dataA,
   input  logic        enA,
   input  logic [9:0]  addrB,
   input  logic [15:0] dataB,
   input  logic        enB,
   input  logic [2:0]  addrI,
   input  logic [3:0]  dataI,
   input  logic        enI,
   input  logic [6:0]  addrO,
   output logic [31:0] dataO,
   input  logic        ap_start,
   output logic        ap_done,
   output logic [3:0]  currInstruction
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_CLEAR, S_STREAM, S_DRAIN, S_WRITE, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [15:0] mem_a [4][256];
   logic [15:0] mem_b [4][256];
   logic [3:0]  mem_i [8];
   logic [31:0] out_mem [128];

   logic [3:0] idx;
   logic [7:0] base;
   logic [4:0] len;
   logic [4:0] cnt;
   logic [3:0] cur_k;
   logic [3:0] inst_k;
   logic       fetch_end;
   logic [7:0] col;

   logic signed [15:0] a_reg [4][4];
   logic signed [15:0] b_reg [4][4];
   logic signed [15:0] a_in  [4][4];
   logic signed [15:0] b_in  [4][4];
   logic signed [31:0] acc   [4][4];

   // ap_start is sampled only in IDLE/DONE; ap_done is a level that holds until the next accepted start.
   assign inst_k          = mem_i[idx[2:0]];
   assign fetch_end       = idx[3] || (inst_k == 4'd0);
   assign col             = base + {3'd0, cnt};
   assign dataO           = out_mem[addrO];
   assign ap_done         = (state == S_DONE);
   assign currInstruction = cur_k;

   // Memories are never reset; the host owns their contents.
   always_ff @(posedge clk) begin
      if (enA) mem_a[addrA[9:8]][addrA[7:0]] <= dataA;
      if (enB) mem_b[addrB[9:8]][addrB[7:0]] <= dataB;
      if (enI) mem_i[addrI] <= dataI;
      if (state == S_WRITE) out_mem[{idx[2:0], cnt[3:0]}] <= acc[cnt[3:2]][cnt[1:0]];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (ap_start) state_nxt = S_FETCH;
         S_FETCH:        state_nxt = fetch_end ? S_DONE : S_CLEAR;
         S_CLEAR:        state_nxt = S_STREAM;
         S_STREAM:       if (cnt == len - 5'd1) state_nxt = S_DRAIN;
         S_DRAIN:        if (cnt == 5'd7) state_nxt = S_WRITE;
         S_WRITE:        if (cnt == 5'd15) state_nxt = S_FETCH;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx   <= '0;
         base  <= '0;
         len   <= '0;
         cnt   <= '0;
         cur_k <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (ap_start) begin
                  idx  <= '0;
                  base <= '0;
                  cnt  <= '0;
               end
            end
            S_FETCH: begin
               cnt <= '0;
               if (fetch_end) begin
                  cur_k <= '0;
               end else begin
                  cur_k <= inst_k;
                  // Later segments carry one leading zero separator column.
                  len   <= (idx == 4'd0) ? {1'b0, inst_k} + 5'd6 : {1'b0, inst_k} + 5'd7;
               end
            end
            S_STREAM: cnt <= (cnt == len - 5'd1) ? '0 : cnt + 5'd1;
            S_DRAIN:  cnt <= (cnt == 5'd7) ? '0 : cnt + 5'd1;
            S_WRITE: begin
               if (cnt == 5'd15) begin
                  cnt  <= '0;
                  base <= base + {3'd0, len};
                  idx  <= idx + 4'd1;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Edge injection: operands enter combinationally from the current column; zeros otherwise.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         a_in[i][0] = (state == S_STREAM) ? mem_a[i][col] : 16'sd0;
         b_in[0][i] = (state == S_STREAM) ? mem_b[i][col] : 16'sd0;
         for (int j = 1; j < 4; j++) begin
            a_in[i][j] = a_reg[i][j-1];
            b_in[j][i] = b_reg[j-1][i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               a_reg[r][c] <= '0;
               b_reg[r][c] <= '0;
               acc[r][c]   <= '0;
            end
         end
      end else if (state == S_CLEAR) begin
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               a_reg[r][c] <= '0;
               b_reg[r][c] <= '0;
               acc[r][c]   <= '0;
            end
         end
      end else if (state == S_STREAM || state == S_DRAIN) begin
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               a_reg[r][c] <= a_in[r][c];
               b_reg[r][c] <= b_in[r][c];
               acc[r][c]   <= acc[r][c] + 32'(a_in[r][c]) * 32'(b_in[r][c]);
            end
         end
      end
   end

endmodule

// File: tb/tb_systolic_mm_top.sv
// Directed bench for systolic_mm_top: hand-computed result tables per run plus
// cycle-exact sequences for multi-instruction, empty-list and mid-run reset.
module tb_systolic_mm_top;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  addrA, addrB;
   logic [15:0] dataA, dataB;
   logic        enA, enB;
   logic [2:0]  addrI;
   logic [3:0]  dataI;
   logic        enI;
   logic [6:0]  addrO;
   logic [31:0] dataO;
   logic        ap_start;
   logic        ap_done;
   logic [3:0]  currInstruction;

   always #5 clk = ~clk;

   systolic_mm_top dut (
      .clk(clk), .rst(rst),
      .addrA(addrA), .dataA(dataA), .enA(enA),
      .addrB(addrB), .dataB(dataB), .enB(enB),
      .addrI(addrI), .dataI(dataI), .enI(enI),
      .addrO(addrO), .dataO(dataO),
      .ap_start(ap_start), .ap_done(ap_done), .currInstruction(currInstruction)
   );

   typedef struct {
      logic [6:0]  addr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   logic [15:0] ta   [4][16];
   logic [15:0] tm_b [16][4];

   int c0 [16] = '{1, 2, 8, 3,  3, 4, 18, 5,  -1, 0, -2, 1,  0, 5, 15, 10};
   int c1 [16] = '{6, 1, 1, 6,  -3, 4, 8, 7,  0, -3, 0, 3,  21, 4, -5, 6};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, $signed(act), act,
                  $signed(exp), exp);
      end
   endtask

   task automatic clear_ops();
      for (int r = 0; r < 4; r++) begin
         for (int cl = 0; cl < 32; cl++) begin
            addrA = 10'(256 * r + cl);
            addrB = 10'(256 * r + cl);
            dataA = '0;
            dataB = '0;
            enA   = 1'b1;
            enB   = 1'b1;
            tick();
         end
      end
      enA = 1'b0;
      enB = 1'b0;
   endtask

   task automatic write_a(input int r, input int cl, input logic [15:0] v);
      addrA = 10'(256 * r + cl);
      dataA = v;
      enA   = 1'b1;
      tick();
      enA   = 1'b0;
   endtask

   task automatic write_b(input int cc, input int cl, input logic [15:0] v);
      addrB = 10'(256 * cc + cl);
      dataB = v;
      enB   = 1'b1;
      tick();
      enB   = 1'b0;
   endtask

   task automatic write_inst(input int a, input int k);
      addrI = 3'(a);
      dataI = 4'(k);
      enI   = 1'b1;
      tick();
      enI   = 1'b0;
   endtask

   // Pre-skewed placement: A[r][k] at column seg+r+k, B[k][c] at column seg+c+k.
   task automatic load_tile(input int seg, input int k);
      for (int r = 0; r < 4; r++)
         for (int kk = 0; kk < k; kk++)
            write_a(r, seg + r + kk, ta[r][kk]);
      for (int cc = 0; cc < 4; cc++)
         for (int kk = 0; kk < k; kk++)
            write_b(cc, seg + cc + kk, tm_b[kk][cc]);
   endtask

   task automatic set_a_row(input int r, input int v0, input int v1, input int v2);
      ta[r][0] = 16'(v0);
      ta[r][1] = 16'(v1);
      ta[r][2] = 16'(v2);
   endtask

   task automatic set_b_row(input int k, input int v0, input int v1, input int v2, input int v3);
      tm_b[k][0] = 16'(v0);
      tm_b[k][1] = 16'(v1);
      tm_b[k][2] = 16'(v2);
      tm_b[k][3] = 16'(v3);
   endtask

   task automatic fill_tiles(input int a_val, input int b_val, input bit a_ident);
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++) begin
            ta[r][k]   = a_ident ? ((r == k) ? 16'd1 : 16'd0) : 16'(a_val);
            tm_b[k][r] = 16'(b_val);
         end
   endtask

   task automatic pulse_start();
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (ap_done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (ap_done !== 1'b1) begin
         failures++;
         $display("FAIL %s: ap_done still %b after %0d cycles, required 1", name, ap_done, budget);
      end
   endtask

   task automatic run_vecs(input string tag);
      foreach (vecs[i]) begin
         addrO = vecs[i].addr;
         #1;
         check32($sformatf("%s[%0d]", tag, vecs[i].addr), dataO, vecs[i].exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; ap_start = 1'b0;
      addrA = '0; dataA = '0; enA = 1'b0;
      addrB = '0; dataB = '0; enB = 1'b0;
      addrI = '0; dataI = '0; enI = 1'b0;
      addrO = '0;
      repeat (3) @(posedge clk);
      #1;
      check32("reset_ap_done", 32'(ap_done), 32'd0);
      check32("reset_curr_inst", 32'(currInstruction), 32'd0);
      rst = 1'b1;
      tick();

      // Identity: A = I, B = 1..16 row-major.
      clear_ops();
      fill_tiles(0, 0, 1'b1);
      for (int k = 0; k < 4; k++)
         for (int c = 0; c < 4; c++)
            tm_b[k][c] = 16'(4 * k + c + 1);
      load_tile(0, 4);
      write_inst(0, 4);
      write_inst(1, 0);
      pulse_start();
      check32("t1_done_low_at_fetch", 32'(ap_done), 32'd0);
      tick();
      check32("t1_curr_inst_running", 32'(currInstruction), 32'd4);
      wait_done("t1_done", 100);
      check32("t1_curr_inst_done", 32'(currInstruction), 32'd0);
      vecs.delete();
      for (int i = 0; i < 16; i++) vecs.push_back('{addr: 7'(i), exp: 32'(i + 1)});
      run_vecs("t1_identity");

      // Signed: A all -1, B all 2.
      clear_ops();
      fill_tiles(-1, 2, 1'b0);
      load_tile(0, 4);
      pulse_start();
      wait_done("t2_done", 100);
      vecs.delete();
      for (int i = 0; i < 16; i++) vecs.push_back('{addr: 7'(i), exp: 32'hFFFF_FFF8});
      run_vecs("t2_signed");

      // Wrap-around: 4 * 0x7FFF^2 exceeds 32 bits.
      clear_ops();
      fill_tiles(32'h7FFF, 32'h7FFF, 1'b0);
      load_tile(0, 4);
      pulse_start();
      wait_done("t3_done", 100);
      vecs.delete();
      for (int i = 0; i < 16; i++) vecs.push_back('{addr: 7'(i), exp: 32'(-262140)});
      run_vecs("t3_wrap");

      // Two instructions: K=2 at column 0, K=3 in a segment at column 8 (data from 9).
      clear_ops();
      set_a_row(0, 1, 2, 0);  set_a_row(1, 3, 4, 0);
      set_a_row(2, -1, 0, 0); set_a_row(3, 0, 5, 0);
      set_b_row(0, 1, 0, 2, -1);
      set_b_row(1, 0, 1, 3, 2);
      load_tile(0, 2);
      set_a_row(0, 1, 1, 1); set_a_row(1, 2, 0, -1);
      set_a_row(2, 0, 3, 0); set_a_row(3, 1, -2, 4);
      set_b_row(0, 1, 2, 3, 4);
      set_b_row(1, 0, -1, 0, 1);
      set_b_row(2, 5, 0, -2, 1);
      load_tile(9, 3);
      write_inst(0, 2);
      write_inst(1, 3);
      write_inst(2, 0);
      pulse_start();
      tick();
      check32("t4_curr_inst_first", 32'(currInstruction), 32'd2);
      // CLEAR -> 8 STREAM + 8 DRAIN + 16 WRITE -> FETCH -> CLEAR of the second instruction.
      repeat (34) tick();
      check32("t4_curr_inst_second", 32'(currInstruction), 32'd3);
      check32("t4_done_low_mid_run", 32'(ap_done), 32'd0);
      wait_done("t4_done", 100);
      vecs.delete();
      for (int i = 0; i < 16; i++) vecs.push_back('{addr: 7'(i), exp: 32'(c0[i])});
      for (int i = 0; i < 16; i++) vecs.push_back('{addr: 7'(16 + i), exp: 32'(c1[i])});
      run_vecs("t4_two_inst");

      // Empty list: DONE two cycles after the start edge, results untouched.
      write_inst(0, 0);
      pulse_start();
      check32("t5_done_cleared", 32'(ap_done), 32'd0);
      tick();
      check32("t5_done_2cyc", 32'(ap_done), 32'd1);
      check32("t5_curr_inst", 32'(currInstruction), 32'd0);
      vecs.delete();
      vecs.push_back('{addr: 7'd0,  exp: 32'(c0[0])});
      vecs.push_back('{addr: 7'd15, exp: 32'(c0[15])});
      vecs.push_back('{addr: 7'd18, exp: 32'(c1[2])});
      vecs.push_back('{addr: 7'd28, exp: 32'(c1[12])});
      run_vecs("t5_unchanged");

      // Reset during STREAM, then a clean rerun: A = I, B all 3.
      clear_ops();
      fill_tiles(0, 3, 1'b1);
      load_tile(0, 4);
      write_inst(0, 4);
      write_inst(1, 0);
      pulse_start();
      repeat (4) tick();
      check32("t6_curr_inst_stream", 32'(currInstruction), 32'd4);
      rst = 1'b0;
      #1;
      check32("t6_rst_ap_done", 32'(ap_done), 32'd0);
      check32("t6_rst_curr_inst", 32'(currInstruction), 32'd0);
      #1;
      rst = 1'b1;
      tick();
      check32("t6_idle_ap_done", 32'(ap_done), 32'd0);
      addrO = 7'd0;
      #1;
      check32("t6_no_partial_write", dataO, 32'(c0[0]));
      pulse_start();
      wait_done("t6_done", 100);
      vecs.delete();
      for (int i = 0; i < 16; i++) vecs.push_back('{addr: 7'(i), exp: 32'd3});
      vecs.push_back('{addr: 7'd16, exp: 32'(c1[0])});
      run_vecs("t6_rerun");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
